// File: rtl/block_accumulator.sv
// Block accumulator: sums KB partial 2x2 products per output tile and
// presents each tile on a valid/ready port, walking tiles row-major.
module block_accumulator #(
    parameter int W     = 8,
    parameter int GUARD = 4,
    parameter int KB    = 2,
    parameter int NB    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic [W-1:0] i_c11,
    input  logic [W-1:0] i_c12,
    input  logic [W-1:0] i_c21,
    input  logic [W-1:0] i_c22,
    input  logic in_valid,
    output logic in_ready,
    output logic [W+GUARD-1:0] o_c11,
    output logic [W+GUARD-1:0] o_c12,
    output logic [W+GUARD-1:0] o_c21,
    output logic [W+GUARD-1:0] o_c22,
    output logic [((NB*NB > 1) ? $clog2(NB*NB) : 1)-1:0] o_tile,
    output logic o_last,
    output logic out_valid,
    input  logic out_ready,
    output logic err
);

    localparam int OW = W + GUARD;
    localparam int NT = NB * NB;
    localparam int TW = (NT > 1) ? $clog2(NT) : 1;
    localparam int KW = (KB > 1) ? $clog2(KB) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(KB - 1);
    localparam logic [TW-1:0] T_LAST = TW'(NT - 1);

    localparam logic [0:0] S_ACC = 1'b0;
    localparam logic [0:0] S_OUT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [TW-1:0] tile_q, tile_d;
    logic          out_valid_q, out_valid_d;
    logic          err_q, err_d;
    logic [OW-1:0] acc_q [4];
    logic [OW-1:0] acc_d [4];
    logic [W-1:0]  in_w  [4];

    assign in_w[0] = i_c11;
    assign in_w[1] = i_c12;
    assign in_w[2] = i_c21;
    assign in_w[3] = i_c22;

    assign in_ready  = (state_q == S_ACC);
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign o_tile    = tile_q;
    assign o_last    = (tile_q == T_LAST);
    assign o_c11     = acc_q[0];
    assign o_c12     = acc_q[1];
    assign o_c21     = acc_q[2];
    assign o_c22     = acc_q[3];

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        tile_d      = tile_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        acc_d       = acc_q;
        // Anything offered while a tile is held is lost, including on the
        // handshake edge itself.
        if (in_valid && !in_ready) begin
            err_d = 1'b1;
        end
        if (state_q == S_ACC) begin
            if (in_valid) begin
                for (int i = 0; i < 4; i++) begin
                    if (k_q == '0) begin
                        acc_d[i] = OW'(in_w[i]);
                    end else begin
                        acc_d[i] = acc_q[i] + OW'(in_w[i]);
                    end
                end
                if (k_q == K_LAST) begin
                    k_d         = '0;
                    state_d     = S_OUT;
                    out_valid_d = 1'b1;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_ACC;
            tile_d      = (tile_q == T_LAST) ? '0 : tile_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_ACC;
            k_q         <= '0;
            tile_q      <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            tile_q      <= tile_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            acc_q       <= acc_d;
        end
    end

endmodule

// File: tb/tb_block_accumulator.sv
// Bench for block_accumulator: three instances (KB=2, 17, 1) checked against
// a transaction-level model of tile sums, tile index and the sticky error.
module tb_block_accumulator;

    localparam int KBV [3] = '{2, 17, 1};

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] di [4];
    logic [2:0] ivl;
    logic       ordy;

    logic        ir [3];
    logic        ov [3];
    logic        er [3];
    logic        ol [3];
    logic [1:0]  ot [3];
    logic [11:0] o11 [3];
    logic [11:0] o12 [3];
    logic [11:0] o21 [3];
    logic [11:0] o22 [3];

    int n_vec = 0;
    int n_err = 0;

    // model state
    int msum [3][4];
    int expc [3][4];
    int cnt  [3];
    bit pend [3];
    int mtile [3];
    bit merr [3];

    always #5 clk = ~clk;

    block_accumulator #(.W(8), .GUARD(4), .KB(2), .NB(2)) u_kb2 (
        .clk(clk), .rst(rst),
        .i_c11(di[0]), .i_c12(di[1]), .i_c21(di[2]), .i_c22(di[3]),
        .in_valid(ivl[0]), .in_ready(ir[0]),
        .o_c11(o11[0]), .o_c12(o12[0]), .o_c21(o21[0]), .o_c22(o22[0]),
        .o_tile(ot[0]), .o_last(ol[0]), .out_valid(ov[0]),
        .out_ready(ordy), .err(er[0])
    );

    block_accumulator #(.W(8), .GUARD(4), .KB(17), .NB(2)) u_kb17 (
        .clk(clk), .rst(rst),
        .i_c11(di[0]), .i_c12(di[1]), .i_c21(di[2]), .i_c22(di[3]),
        .in_valid(ivl[1]), .in_ready(ir[1]),
        .o_c11(o11[1]), .o_c12(o12[1]), .o_c21(o21[1]), .o_c22(o22[1]),
        .o_tile(ot[1]), .o_last(ol[1]), .out_valid(ov[1]),
        .out_ready(ordy), .err(er[1])
    );

    block_accumulator #(.W(8), .GUARD(4), .KB(1), .NB(2)) u_kb1 (
        .clk(clk), .rst(rst),
        .i_c11(di[0]), .i_c12(di[1]), .i_c21(di[2]), .i_c22(di[3]),
        .in_valid(ivl[2]), .in_ready(ir[2]),
        .o_c11(o11[2]), .o_c12(o12[2]), .o_c21(o21[2]), .o_c22(o22[2]),
        .o_tile(ot[2]), .o_last(ol[2]), .out_valid(ov[2]),
        .out_ready(ordy), .err(er[2])
    );

    // Apply one cycle of stimulus, advance the model, settle after the edge.
    task automatic step(input logic r, input logic [2:0] v,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d,
                        input logic rd);
        int x [4];
        rst   = r;
        ivl   = v;
        di[0] = a;
        di[1] = b;
        di[2] = c;
        di[3] = d;
        ordy  = rd;
        x     = '{int'(a), int'(b), int'(c), int'(d)};
        @(posedge clk);
        for (int u = 0; u < 3; u++) begin
            if (!r) begin
                cnt[u]   = 0;
                pend[u]  = 0;
                mtile[u] = 0;
                merr[u]  = 0;
                for (int j = 0; j < 4; j++) begin
                    msum[u][j] = 0;
                    expc[u][j] = 0;
                end
            end else if (pend[u]) begin
                if (v[u]) merr[u] = 1;
                if (rd) begin
                    pend[u]  = 0;
                    mtile[u] = (mtile[u] + 1) % 4;
                end
            end else if (v[u]) begin
                for (int j = 0; j < 4; j++) begin
                    msum[u][j] = (cnt[u] == 0) ? x[j] : msum[u][j] + x[j];
                end
                cnt[u]++;
                if (cnt[u] == KBV[u]) begin
                    cnt[u]  = 0;
                    pend[u] = 1;
                    for (int j = 0; j < 4; j++) begin
                        expc[u][j] = msum[u][j] % 4096;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic idle(input logic rd);
        step(1'b1, 3'b000, 8'd0, 8'd0, 8'd0, 8'd0, rd);
    endtask

    task automatic test_reset;
        step(1'b0, 3'b000, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        step(1'b0, 3'b111, 8'd5, 8'd5, 8'd5, 8'd5, 1'b1);
        for (int u = 0; u < 3; u++) begin
            n_vec++;
            if (ir[u] !== 1'b1 || ov[u] !== 1'b0 || er[u] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_flags dut%0d: in_ready=%b out_valid=%b err=%b, want 1 0 0",
                         u, ir[u], ov[u], er[u]);
            end
            n_vec++;
            if (o11[u] !== 0 || o12[u] !== 0 || o21[u] !== 0 || o22[u] !== 0) begin
                n_err++;
                $display("FAIL reset_oc dut%0d: got %0d %0d %0d %0d, want zeros",
                         u, o11[u], o12[u], o21[u], o22[u]);
            end
            n_vec++;
            if (ot[u] !== 2'd0 || ol[u] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_tile dut%0d: o_tile=%0d o_last=%b, want 0 0",
                         u, ot[u], ol[u]);
            end
        end
    endtask

    task automatic test_basic;
        step(1'b1, 3'b001, 8'd10, 8'd20, 8'd30, 8'd40, 1'b1);
        n_vec++;
        if (ov[0] !== 1'b0) begin
            n_err++;
            $display("FAIL basic_early_valid: out_valid=%b, want 0", ov[0]);
        end
        step(1'b1, 3'b001, 8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
        n_vec++;
        if (ov[0] !== 1'b1) begin
            n_err++;
            $display("FAIL basic_valid: out_valid=%b, want 1", ov[0]);
        end
        n_vec++;
        if (o11[0] !== 12'd11 || o12[0] !== 12'd22 ||
            o21[0] !== 12'd33 || o22[0] !== 12'd44) begin
            n_err++;
            $display("FAIL basic_tile: got %0d %0d %0d %0d, want 11 22 33 44",
                     o11[0], o12[0], o21[0], o22[0]);
        end
        n_vec++;
        if (ot[0] !== 2'd0 || ol[0] !== 1'b0) begin
            n_err++;
            $display("FAIL basic_index: o_tile=%0d o_last=%b, want 0 0", ot[0], ol[0]);
        end
        idle(1'b1);
        n_vec++;
        if (ov[0] !== 1'b0 || ot[0] !== 2'd1) begin
            n_err++;
            $display("FAIL basic_one_cycle: out_valid=%b o_tile=%0d, want 0 1",
                     ov[0], ot[0]);
        end
    endtask

    task automatic test_kb17;
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 3'b010, 8'd255, 8'd255, 8'd255, 8'd255, 1'b1);
            if (i == 15) begin
                n_vec++;
                if (ov[1] !== 1'b0) begin
                    n_err++;
                    $display("FAIL kb17_early: out_valid=%b after 16, want 0", ov[1]);
                end
            end
        end
        n_vec++;
        if (ov[1] !== 1'b1 || o11[1] !== 12'd239 || o12[1] !== 12'd239 ||
            o21[1] !== 12'd239 || o22[1] !== 12'd239 || er[1] !== 1'b0) begin
            n_err++;
            $display("FAIL kb17_wrap: valid=%b got %0d %0d %0d %0d err=%b, want 1 239x4 0",
                     ov[1], o11[1], o12[1], o21[1], o22[1], er[1]);
        end
        idle(1'b1);
    endtask

    task automatic test_stall;
        logic [7:0] r [4];
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) r[j] = 8'($urandom);
            step(1'b1, 3'b001, r[0], r[1], r[2], r[3], 1'b0);
        end
        for (int c = 0; c < 5; c++) begin
            step(1'b1, (c == 1) ? 3'b001 : 3'b000, 8'd9, 8'd9, 8'd9, 8'd9, 1'b0);
            n_vec++;
            if (ov[0] !== 1'b1 || ir[0] !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold c%0d: out_valid=%b in_ready=%b, want 1 0",
                         c, ov[0], ir[0]);
            end
            n_vec++;
            if (o11[0] !== expc[0][0][11:0] || o12[0] !== expc[0][1][11:0] ||
                o21[0] !== expc[0][2][11:0] || o22[0] !== expc[0][3][11:0]) begin
                n_err++;
                $display("FAIL stall_data c%0d: got %0d %0d %0d %0d, want %0d %0d %0d %0d",
                         c, o11[0], o12[0], o21[0], o22[0],
                         expc[0][0], expc[0][1], expc[0][2], expc[0][3]);
            end
            n_vec++;
            if (er[0] !== (c >= 1)) begin
                n_err++;
                $display("FAIL stall_err c%0d: err=%b, want %b", c, er[0], c >= 1);
            end
        end
        idle(1'b1);
        n_vec++;
        if (ov[0] !== 1'b0 || ot[0] !== 2'd2 || ir[0] !== 1'b1) begin
            n_err++;
            $display("FAIL stall_release: out_valid=%b o_tile=%0d in_ready=%b, want 0 2 1",
                     ov[0], ot[0], ir[0]);
        end
    endtask

    task automatic test_tiles;
        step(1'b0, 3'b000, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        for (int t = 0; t < 5; t++) begin
            for (int k = 0; k < 2; k++) begin
                step(1'b1, 3'b001, 8'($urandom), 8'($urandom),
                     8'($urandom), 8'($urandom), 1'b1);
            end
            n_vec++;
            if (ov[0] !== 1'b1 || ot[0] !== 2'(t % 4) || ol[0] !== (t % 4 == 3)) begin
                n_err++;
                $display("FAIL tiles t%0d: valid=%b o_tile=%0d o_last=%b, want 1 %0d %b",
                         t, ov[0], ot[0], ol[0], t % 4, t % 4 == 3);
            end
            n_vec++;
            if (o11[0] !== expc[0][0][11:0] || o22[0] !== expc[0][3][11:0]) begin
                n_err++;
                $display("FAIL tiles_data t%0d: got %0d %0d, want %0d %0d",
                         t, o11[0], o22[0], expc[0][0], expc[0][3]);
            end
            idle(1'b1);
        end
    endtask

    task automatic test_reset_mid;
        step(1'b1, 3'b001, 8'd5, 8'd5, 8'd5, 8'd5, 1'b1);
        step(1'b0, 3'b000, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
        step(1'b1, 3'b001, 8'd1, 8'd1, 8'd1, 8'd1, 1'b1);
        step(1'b1, 3'b001, 8'd2, 8'd2, 8'd2, 8'd2, 1'b1);
        n_vec++;
        if (ov[0] !== 1'b1 || o11[0] !== 12'd3 || o12[0] !== 12'd3 ||
            o21[0] !== 12'd3 || o22[0] !== 12'd3) begin
            n_err++;
            $display("FAIL reset_mid_tile: valid=%b got %0d %0d %0d %0d, want 1 3 3 3 3",
                     ov[0], o11[0], o12[0], o21[0], o22[0]);
        end
        n_vec++;
        if (ot[0] !== 2'd0 || er[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_idx: o_tile=%0d err=%b, want 0 0", ot[0], er[0]);
        end
        idle(1'b1);
    endtask

    task automatic test_back_to_back;
        step(1'b1, 3'b100, 8'd7, 8'd8, 8'd9, 8'd10, 1'b0);
        n_vec++;
        if (ov[2] !== 1'b1 || o11[2] !== 12'd7 || o12[2] !== 12'd8 ||
            o21[2] !== 12'd9 || o22[2] !== 12'd10) begin
            n_err++;
            $display("FAIL kb1_tile: valid=%b got %0d %0d %0d %0d, want 1 7 8 9 10",
                     ov[2], o11[2], o12[2], o21[2], o22[2]);
        end
        step(1'b1, 3'b100, 8'd1, 8'd1, 8'd1, 8'd1, 1'b1);
        n_vec++;
        if (er[2] !== 1'b1 || ov[2] !== 1'b0 || ir[2] !== 1'b1) begin
            n_err++;
            $display("FAIL kb1_b2b: err=%b valid=%b in_ready=%b, want 1 0 1",
                     er[2], ov[2], ir[2]);
        end
        step(1'b1, 3'b100, 8'd3, 8'd3, 8'd3, 8'd3, 1'b0);
        n_vec++;
        if (ov[2] !== 1'b1 || o11[2] !== 12'd3 || ot[2] !== 2'd1) begin
            n_err++;
            $display("FAIL kb1_next: valid=%b c11=%0d o_tile=%0d, want 1 3 1",
                     ov[2], o11[2], ot[2]);
        end
        idle(1'b1);
    endtask

    task automatic test_random;
        logic       r;
        logic [2:0] v;
        step(1'b0, 3'b000, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 99) != 0);
            v = 3'($urandom);
            step(r, v, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 2) != 0));
            for (int u = 0; u < 3; u++) begin
                n_vec++;
                if (ir[u] !== !pend[u] || ov[u] !== pend[u] || er[u] !== merr[u]) begin
                    n_err++;
                    $display("FAIL rand_ctl n%0d dut%0d: ready=%b valid=%b err=%b, want %b %b %b",
                             n, u, ir[u], ov[u], er[u], !pend[u], pend[u], merr[u]);
                end
                n_vec++;
                if (ot[u] !== 2'(mtile[u]) || ol[u] !== (mtile[u] == 3)) begin
                    n_err++;
                    $display("FAIL rand_idx n%0d dut%0d: o_tile=%0d o_last=%b, want %0d",
                             n, u, ot[u], ol[u], mtile[u]);
                end
                if (pend[u]) begin
                    n_vec++;
                    if (o11[u] !== expc[u][0][11:0] || o12[u] !== expc[u][1][11:0] ||
                        o21[u] !== expc[u][2][11:0] || o22[u] !== expc[u][3][11:0]) begin
                        n_err++;
                        $display("FAIL rand_data n%0d dut%0d: got %0d %0d %0d %0d, want %0d %0d %0d %0d",
                                 n, u, o11[u], o12[u], o21[u], o22[u],
                                 expc[u][0], expc[u][1], expc[u][2], expc[u][3]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst  = 1'b0;
        ivl  = 3'b000;
        ordy = 1'b0;
        for (int j = 0; j < 4; j++) di[j] = 8'd0;
        test_reset;
        test_basic;
        test_kb17;
        test_stall;
        test_tiles;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/block_accumulator.md
BLOCK_ACCUMULATOR -- requirements
Module: block_accumulator

Interface
REQ-001 SHALL have parameter W, default 8; width of each incoming 2x2 product element.
REQ-002 SHALL have parameter GUARD, default 4; extra accumulator bits, so output width is W+GUARD.
REQ-003 SHALL have parameter KB, default 2; number of partial block products summed per output tile (KB >= 1).
REQ-004 SHALL have parameter NB, default 2; number of block rows and columns of the result, so a result has NB*NB tiles.
REQ-005 SHALL have port clk, input, 1 bit; the single clock, with all state updated on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit; synchronous active-low reset, sampled on clk rising edge.
REQ-007 SHALL have ports i_c11, i_c12, i_c21, i_c22, each input, W bits; unsigned partial-product elements from the upstream 2x2 multiplier.
REQ-008 SHALL have port in_valid, input, 1 bit; upstream done pulse marking that i_c* are valid.
REQ-009 SHALL have port in_ready, output, 1 bit; asserted when the block can accept a product.
REQ-010 SHALL have ports o_c11, o_c12, o_c21, o_c22, each output, W+GUARD bits; accumulated tile elements.
REQ-011 SHALL have port o_tile, output, clog2(NB*NB) bits (minimum 1); index of the presented tile, row-major.
REQ-012 SHALL have port o_last, output, 1 bit; high while the presented tile is tile NB*NB-1.
REQ-013 SHALL have port out_valid, output, 1 bit; a tile is presented.
REQ-014 SHALL have port out_ready, input, 1 bit; downstream accepts the tile.
REQ-015 SHALL have port err, output, 1 bit; sticky flag for a dropped product.

Function
REQ-016 SHALL implement two states, S_ACC (collecting products) and S_OUT (presenting a tile).
REQ-017 in_ready SHALL be combinational and equal to (state == S_ACC).
REQ-018 A product SHALL be accepted on a rising edge with in_valid=1 and in_ready=1.
REQ-019 On acceptance with k_cnt=0, each accumulator SHALL load the zero-extended input.
REQ-020 On acceptance with k_cnt>0, each accumulator SHALL add the zero-extended input, modulo 2^(W+GUARD), discarding any carry.
REQ-021 On acceptance with k_cnt<KB-1, the block SHALL increment k_cnt and remain in S_ACC.
REQ-022 On acceptance with k_cnt=KB-1, the block SHALL reset k_cnt to 0, enter S_OUT, and set out_valid=1 on that same edge, so the tile is visible one cycle after the final in_valid.
REQ-023 o_c* SHALL be driven directly by the accumulator registers, and SHALL hold stable while out_valid=1.
REQ-024 o_tile and o_last SHALL hold stable while out_valid=1.
REQ-025 In S_OUT, when out_valid=1 and out_ready=1 on an edge, the block SHALL clear out_valid, return to S_ACC, and increment the tile index.
REQ-026 The tile index SHALL wrap from NB*NB-1 to 0.
REQ-027 in_valid=1 while in_ready=0 SHALL drop the product, leave accumulators unchanged, and set err=1 on that edge; err SHALL clear only on reset.
REQ-028 When the output handshake and in_valid occur on the same edge, in_valid SHALL be treated as dropped per REQ-027; the freed slot becomes ready only on the next cycle.
REQ-029 out_ready SHALL be ignored while out_valid=0.
REQ-030 With KB=1, every accepted product SHALL pass straight to S_OUT.

Reset
REQ-031 While rst=0 at a clk edge, the block SHALL set state=S_ACC, k_cnt=0, tile index=0, accumulators=0, out_valid=0 and err=0.
REQ-032 After reset, in_ready SHALL be 1 and o_c*=0, o_tile=0, o_last=0.
REQ-033 Reset mid-accumulation or mid-presentation SHALL discard the partial sums and any pending tile without emitting it.

Verification
REQ-034 KB=2, out_ready=1: products (10,20,30,40) then (1,2,3,4) -> out_valid for exactly one cycle, starting the cycle after the 2nd in_valid, with o_c=(11,22,33,44), o_tile=0, o_last=0.
REQ-035 KB=17: seventeen products of all 255 -> o_c all 239 (4335 mod 4096), err=0.
REQ-036 out_ready held 0 for 5 cycles, with an in_valid pulse of (9,9,9,9) during S_OUT -> o_c unchanged, out_valid held, in_ready=0, and err=1 from the next cycle onward.
REQ-037 Four complete tiles, NB=2 -> o_tile sequence 0,1,2,3 with o_last=1 only on tile 3; the fifth tile shows o_tile=0.
REQ-038 One product (5,5,5,5), then rst=0 for one cycle, then (1,1,1,1),(2,2,2,2) -> tile (3,3,3,3), o_tile=0, err=0.
REQ-039 KB=1: a product (7,8,9,10) -> tile (7,8,9,10) on the next cycle; a back-to-back in_valid on the output-handshake cycle -> err=1.
